mac_result_collector: RTL and testbench
=======================================

Name: mac_result_collector

Overview:
Downstream stage of mac_array. Captures each lane's accumulator on the rising edge of its valid_out and holds one result per enabled lane. Once all enabled lanes are captured, it requantizes each result (shift, optional ReLU, saturate to W bits) and streams it in lane order over a valid/ready port that feeds the next layer's a_in. After the last beat it pulses layer_start for layering_pipeline_ctrl.

Parameters:
W, 8, requantized output magnitude width (signed W-bit range)
ACC_W, 16, accumulator / output data width
N_MACS, 4, lane count; fixed at 4 to match mac_array lane ports
SHIFT, 0, arithmetic right shift applied before saturation (0..ACC_W-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the rising clk edge)
lane_mask  in  N_MACS  lanes participating in the current batch; held stable while busy
acc_in_0..acc_in_3  in  ACC_W each  signed accumulators from mac_array acc_out_0..3
valid_in  in  N_MACS  level valids from mac_array valid_out
out_data  out  ACC_W  requantized value, sign-extended W-bit
out_lane  out  2  lane index of the current out_data
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts the beat when out_valid&&out_ready
layer_start  out  1  one-cycle pulse after the batch drains
busy  out  1  high when any lane is captured or state is not COLLECT
overrun  out  1  sticky; a valid rising edge was dropped
clear_overrun  in  1  clears overrun (set takes priority in the same cycle)

Behaviour:
- Reset (rst==0): state=COLLECT, captured=0, valid_q=0, mask_q=lane_mask, out_valid=0, out_lane=0, layer_start=0, overrun=0, buffers=0. out_data=0 follows from buf=0.
- Edge detect: rise = valid_in & ~valid_q; valid_q <= valid_in every cycle. valid_q resets to 0, so a level already high at reset release counts as a rise.
- COLLECT: for each lane i in mask_q with rise[i] and !captured[i]: buf[i] <= acc_in_i and captured[i] <= 1.
  - A rise on an already-captured lane is dropped and sets overrun. Rises on unmasked lanes are ignored.
  - When (captured | newly captured) == mask_q and mask_q != 0, go to DRAIN next cycle.
  - mask_q==0: the block stays in COLLECT and never drains.
- DRAIN: out_valid=1.
  - out_lane = lowest set bit of the remaining bits; out_data = requant(buf[out_lane]).
  - On out_valid&&out_ready, clear that remaining bit. The next lane is presented the following cycle, allowing one beat per cycle.
  - out_data/out_lane stay stable while out_valid && !out_ready.
  - Any rise during DRAIN is dropped and sets overrun.
  - When the last bit is accepted, go to DONE.
- DONE: one cycle. layer_start=1 and out_valid=0. Then captured=0, mask_q<=lane_mask, return to COLLECT. A rise in the DONE cycle is dropped and sets overrun.
- Latency: last capture at edge t → out_valid=1 after edge t+1. With out_ready tied high, K lanes give layer_start high in cycle t+K+1.
- requant(x), all signed:
  - s = x >>> SHIFT
  - if s > 2^(W-1)-1 then 2^(W-1)-1; if s < -2^(W-1) then -2^(W-1)
  - sign-extend the W-bit result to ACC_W.
- Reset mid-operation: rst==0 in any state aborts the batch. The next cycle shows out_valid=0 and layer_start=0, with no partial beats afterwards.
- overrun: set has priority over clear_overrun in the same cycle.

Optional Feature:
COLLECT_RELU_EN: when defined, requant clamps s<0 to 0 before saturation, so outputs lie in 0..2^(W-1)-1. When undefined, signed values pass through to saturation unchanged.

Decomposition:
- Package systolic_pkg holds:
  - the collector state enum {COLLECT, DRAIN, DONE}
  - default W/ACC_W/N_MACS constants
  - the lane-index width localparam
- One sub-module, requant_sat (combinational shift + optional ReLU + saturate, parameterized by W/ACC_W/SHIFT), instantiated once on the selected buffer.

Test Plan:
1. mask=1111, SHIFT=0, weights 2,3,5,7, a=10 → captures 20,30,50,70. Stream out_lane 0..3 with data 20,30,50,70 on consecutive cycles (out_ready=1). layer_start pulses exactly once, one cycle after the last beat.
2. Saturation: acc 300, -200, 127, -128 → out_data 127, -128, 127, -128 without macro. With COLLECT_RELU_EN → 127, 0, 127, 0.
3. Backpressure: out_ready=0 for 3 cycles on lane 1 (value 30) → out_data=30 and out_lane=1 held all 3 cycles; lane 2 appears the cycle after the ready handshake.
4. Overrun: two rising edges on lane 0 (20 then 99) before lane 3 arrives → buf0 stays 20, overrun=1 until clear_overrun=1. A rise during DRAIN also sets overrun.
5. mask=0011, SHIFT=2, acc 40,81 → outputs 10,20 only (lanes 0,1). layer_start follows the second beat; lanes 2/3 valids are ignored.
6. rst=0 for one cycle while out_valid=1 on lane 1 → next cycle out_valid=0, busy=0, layer_start=0. A fresh batch then completes normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic result path: collector states,
// default widths and a lowest-set-lane helper used to order the drain.
package systolic_pkg;

  localparam int DEF_W      = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_N_MACS = 4;
  localparam int LANE_W     = $clog2(DEF_N_MACS);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } coll_state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [LANE_W-1:0] lowest_lane(input logic [DEF_N_MACS-1:0] m);
    logic [LANE_W-1:0] idx;
    idx = '0;
    for (int i = DEF_N_MACS - 1; i >= 0; i--) begin
      if (m[i]) idx = LANE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantizer: arithmetic right shift, optional ReLU, then saturation to a
// signed W-bit range, sign-extended back to ACC_W.
// Optional feature macro: COLLECT_RELU_EN (negative values clamp to zero).
module requant_sat #(
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] i_x,
  output logic signed [ACC_W-1:0] o_y
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_W-1:0] w_s;
  logic signed [ACC_W-1:0] w_r;

  assign w_s = i_x >>> SHIFT;

`ifdef COLLECT_RELU_EN
  assign w_r = w_s[ACC_W-1] ? '0 : w_s;
`else
  assign w_r = w_s;
`endif

  // Clamp into the signed W-bit range.
  always_comb begin
    o_y = w_r;
    if (w_r > MAX_V)      o_y = MAX_V;
    else if (w_r < MIN_V) o_y = MIN_V;
  end

endmodule

// File: rtl/mac_result_collector.sv
// Collects one accumulator per enabled mac_array lane (captured on the rising
// edge of that lane's valid), then streams requantized results in lane order
// over a valid/ready port and pulses layer_start once the batch has drained.
// Optional feature macro: COLLECT_RELU_EN (forwarded to requant_sat).
//
// state   | meaning
// COLLECT | waiting for every lane in mask_q to deliver one result
// DRAIN   | presenting captured lanes lowest-first, one beat per handshake
// DONE    | single cycle: layer_start high, then reload mask and collect
module mac_result_collector
  import systolic_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int N_MACS = DEF_N_MACS,
  parameter int SHIFT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_MACS-1:0]  lane_mask,
  input  logic [ACC_W-1:0]   acc_in_0,
  input  logic [ACC_W-1:0]   acc_in_1,
  input  logic [ACC_W-1:0]   acc_in_2,
  input  logic [ACC_W-1:0]   acc_in_3,
  input  logic [N_MACS-1:0]  valid_in,
  output logic [ACC_W-1:0]   out_data,
  output logic [LANE_W-1:0]  out_lane,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               layer_start,
  output logic               busy,
  output logic               overrun,
  input  logic               clear_overrun
);

  coll_state_e        r_state;
  logic [N_MACS-1:0]  r_valid_q;
  logic [N_MACS-1:0]  r_captured;
  logic [N_MACS-1:0]  r_mask_q;
  logic [N_MACS-1:0]  r_remaining;
  logic [ACC_W-1:0]   r_buf [N_MACS];
  logic               r_out_valid;
  logic [LANE_W-1:0]  r_out_lane;
  logic               r_layer_start;
  logic               r_overrun;

  logic [ACC_W-1:0]   w_acc [N_MACS];
  logic [N_MACS-1:0]  w_rise;
  logic [N_MACS-1:0]  w_new;
  logic [N_MACS-1:0]  w_cap_all;
  logic [N_MACS-1:0]  w_rem_next;
  logic               w_ovr_set;
  logic [ACC_W-1:0]   w_sel;
  logic [ACC_W-1:0]   w_req;

  assign w_acc[0] = acc_in_0;
  assign w_acc[1] = acc_in_1;
  assign w_acc[2] = acc_in_2;
  assign w_acc[3] = acc_in_3;

  assign w_rise     = valid_in & ~r_valid_q;
  assign w_new      = w_rise & r_mask_q & ~r_captured;
  assign w_cap_all  = r_captured | w_new;
  // Outside COLLECT every rise is a lost result; inside, only repeats on masked lanes are.
  assign w_ovr_set  = (r_state == COLLECT) ? |(w_rise & r_mask_q & r_captured) : |w_rise;
  assign w_rem_next = r_remaining & ~(N_MACS'(1) << r_out_lane);
  assign w_sel      = r_buf[r_out_lane];

  requant_sat #(
    .W     (W),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .i_x (w_sel),
    .o_y (w_req)
  );

  assign out_data    = w_req;
  assign out_lane    = r_out_lane;
  assign out_valid   = r_out_valid;
  assign layer_start = r_layer_start;
  assign overrun     = r_overrun;
  assign busy        = (|r_captured) || (r_state != COLLECT);

  // Collector FSM with edge detect, capture buffers and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= COLLECT;
      r_valid_q     <= '0;
      r_captured    <= '0;
      r_mask_q      <= lane_mask;
      r_remaining   <= '0;
      r_out_valid   <= 1'b0;
      r_out_lane    <= '0;
      r_layer_start <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < N_MACS; i++) r_buf[i] <= '0;
    end else begin
      r_valid_q <= valid_in;

      if (w_ovr_set)          r_overrun <= 1'b1;
      else if (clear_overrun) r_overrun <= 1'b0;

      case (r_state)
        COLLECT: begin
          for (int i = 0; i < N_MACS; i++) begin
            if (w_new[i]) r_buf[i] <= w_acc[i];
          end
          r_captured <= w_cap_all;
          if ((r_mask_q != '0) && (w_cap_all == r_mask_q)) begin
            r_state     <= DRAIN;
            r_remaining <= r_mask_q;
          end
        end
        DRAIN: begin
          // First DRAIN cycle only loads the lane; afterwards one beat per handshake.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_lane  <= lowest_lane(r_remaining);
          end else if (out_ready) begin
            r_remaining <= w_rem_next;
            if (w_rem_next == '0) begin
              r_out_valid   <= 1'b0;
              r_layer_start <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_out_lane <= lowest_lane(w_rem_next);
            end
          end
        end
        DONE: begin
          r_layer_start <= 1'b0;
          r_captured    <= '0;
          r_mask_q      <= lane_mask;
          r_state       <= COLLECT;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector. Two instances share stimulus
// (SHIFT=0 and SHIFT=2); expected beats come from a queue filled by the
// stimulus and a floor-division/clamp model of the requantizer.
module tb_mac_result_collector;

  localparam int ACC_W  = 16;
  localparam int NO_DUP = 32'h7fff_ffff;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        lane_mask;
  logic [ACC_W-1:0]  acc_in [4];
  logic [3:0]        valid_in;
  logic              out_ready;
  logic              clear_overrun;

  logic [ACC_W-1:0]  out_data,  out_data2;
  logic [1:0]        out_lane,  out_lane2;
  logic              out_valid, out_valid2;
  logic              layer_start, layer_start2;
  logic              busy, busy2;
  logic              overrun, overrun2;

  always #5 clk = ~clk;

  mac_result_collector #(.W(8), .ACC_W(ACC_W), .N_MACS(4), .SHIFT(0)) u_dut (
    .clk (clk), .rst (rst), .lane_mask (lane_mask),
    .acc_in_0 (acc_in[0]), .acc_in_1 (acc_in[1]), .acc_in_2 (acc_in[2]), .acc_in_3 (acc_in[3]),
    .valid_in (valid_in), .out_data (out_data), .out_lane (out_lane), .out_valid (out_valid),
    .out_ready (out_ready), .layer_start (layer_start), .busy (busy), .overrun (overrun),
    .clear_overrun (clear_overrun)
  );

  mac_result_collector #(.W(8), .ACC_W(ACC_W), .N_MACS(4), .SHIFT(2)) u_dut_s2 (
    .clk (clk), .rst (rst), .lane_mask (lane_mask),
    .acc_in_0 (acc_in[0]), .acc_in_1 (acc_in[1]), .acc_in_2 (acc_in[2]), .acc_in_3 (acc_in[3]),
    .valid_in (valid_in), .out_data (out_data2), .out_lane (out_lane2), .out_valid (out_valid2),
    .out_ready (out_ready), .layer_start (layer_start2), .busy (busy2), .overrun (overrun2),
    .clear_overrun (clear_overrun)
  );

  typedef struct {
    int lane;
    int val;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc = 0;
  int    last_pop_cyc = -10;
  int    ls_count = 0;
  bit    pop_prev = 0;
  bit    exp_ovr = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // floor(x / 2^sh), optional ReLU, clamp to signed 8-bit
  function automatic int rq(input int x, input int sh);
    int d, s;
    d = 1 << sh;
    s = (x >= 0) ? (x / d) : -((-x + d - 1) / d);
`ifdef COLLECT_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: every presented beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if (pop_prev && exp_q.size() > 0) check_val("no_bubble", int'(out_valid), 1);
      pop_prev = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_val("beat_unexpected", 1, 0);
        end else begin
          check_val("beat_lane", int'(out_lane), exp_q[0].lane);
          check_val("beat_data", int'($signed(out_data)), rq(exp_q[0].val, 0));
          check_val("beat_data_s2", int'($signed(out_data2)), rq(exp_q[0].val, 2));
          if (out_ready) begin
            void'(exp_q.pop_front());
            pop_prev = 1;
            last_pop_cyc = cyc;
          end
        end
      end
      if (layer_start) begin
        ls_count++;
        check_val("ls_after_last", cyc - last_pop_cyc, 1);
        check_val("ls_queue_empty", exp_q.size(), 0);
      end
    end else begin
      pop_prev = 0;
    end
  end

  task automatic pulse(input int lane, input int val);
    acc_in[lane]   = ACC_W'(val);
    valid_in[lane] = 1'b1;
    step();
    valid_in[lane] = 1'b0;
    acc_in[lane]   = ACC_W'($urandom);
    step();
  endtask

  // mode: 0 ready high, 1 random ready, 2 stall 3 cycles on lane 1
  task automatic run_batch(input logic [3:0] mask, input int vals[4], input int dup_val,
                           input int mode, input int drain_rise, input bit abort,
                           input logic [3:0] next_mask);
    int masked[$];
    int k, n, hold, lane1cnt, ls0, last, j, tmp;
    ls0 = ls_count;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        exp_q.push_back('{i, vals[i]});
        masked.push_back(i);
        k++;
      end
    end
    for (int i = masked.size() - 1; i > 0; i--) begin
      j = $urandom_range(i);
      tmp = masked[i]; masked[i] = masked[j]; masked[j] = tmp;
    end
    out_ready = (mode == 0);
    for (int i = 0; i < 4; i++) if (!mask[i]) pulse(i, int'($urandom_range(500)));
    for (int i = 0; i < masked.size() - 1; i++) begin
      pulse(masked[i], vals[masked[i]]);
      if (i == 0 && dup_val != NO_DUP) begin
        pulse(masked[0], dup_val);
        exp_ovr = 1;
      end
    end
    last = masked[masked.size() - 1];
    acc_in[last]   = ACC_W'(vals[last]);
    valid_in[last] = 1'b1;
    step();
    valid_in[last] = 1'b0;
    acc_in[last]   = ACC_W'($urandom);
    check_val("lat_pre", int'(out_valid), 0);
    step();
    check_val("lat_first", int'(out_valid), 1);
    check_val("busy_drain", int'(busy), 1);

    n = 0; hold = 0; lane1cnt = 0;
    while (!layer_start && n < 80) begin
      if (abort && out_valid && out_lane == 2'd1) begin
        lane_mask = next_mask;
        rst = 1'b0;
        out_ready = 1'b0;
        step();
        check_val("abort_valid", int'(out_valid), 0);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_ls", int'(layer_start), 0);
        rst = 1'b1;
        exp_q.delete();
        exp_ovr = 0;
        return;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(1));
        default: begin
          if (out_valid && out_lane == 2'd1 && hold < 3) begin
            out_ready = 1'b0;
            hold++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (out_valid && out_lane == 2'd1) lane1cnt++;
      if (drain_rise >= 0) begin
        if (n == 0) begin
          valid_in[drain_rise] = 1'b1;
          exp_ovr = 1;
        end
        if (n == 1) valid_in[drain_rise] = 1'b0;
      end
      step();
      n++;
    end
    valid_in  = '0;
    lane_mask = next_mask;
    out_ready = 1'b0;
    if (n >= 80) begin
      check_val("drain_timeout", 0, 1);
      return;
    end
    if (mode == 0) check_val("ls_latency", n, k);
    if (mode == 2) check_val("bp_lane1_cycles", lane1cnt, 4);
    step();
    check_val("ls_single", int'(layer_start), 0);
    check_val("busy_idle", int'(busy), 0);
    check_val("ls_count", ls_count - ls0, 1);
    check_val("all_beats", exp_q.size(), 0);
    check_val("overrun", int'(overrun), int'(exp_ovr));
    if (exp_ovr) begin
      clear_overrun = 1'b1;
      step();
      clear_overrun = 1'b0;
      check_val("overrun_clear", int'(overrun), 0);
      exp_ovr = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[4];
    logic [3:0] cur_mask, nxt_mask;
    int dup, dr, pc;

    rst = 1'b0;
    lane_mask = 4'hF;
    valid_in = '0;
    out_ready = 1'b0;
    clear_overrun = 1'b0;
    for (int i = 0; i < 4; i++) acc_in[i] = '0;
    repeat (3) step();
    check_val("rst_valid", int'(out_valid), 0);
    check_val("rst_lane", int'(out_lane), 0);
    check_val("rst_data", int'(out_data), 0);
    check_val("rst_ls", int'(layer_start), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_overrun", int'(overrun), 0);
    rst = 1'b1;
    step();

    v = '{20, 30, 50, 70};
    run_batch(4'hF, v, NO_DUP, 0, -1, 1'b0, 4'hF);
    v = '{300, -200, 127, -128};
    run_batch(4'hF, v, NO_DUP, 0, -1, 1'b0, 4'hF);
    v = '{20, 30, 50, 70};
    run_batch(4'hF, v, NO_DUP, 2, -1, 1'b0, 4'hF);
    run_batch(4'hF, v, 99, 0, -1, 1'b0, 4'hF);
    run_batch(4'hF, v, NO_DUP, 0, 2, 1'b0, 4'b0011);
    v = '{40, 81, 500, -7};
    run_batch(4'b0011, v, NO_DUP, 0, -1, 1'b0, 4'hF);
    v = '{20, 30, 50, 70};
    run_batch(4'hF, v, NO_DUP, 0, -1, 1'b1, 4'hF);
    step();
    v = '{-5, 1000, -1000, 64};
    run_batch(4'hF, v, NO_DUP, 0, -1, 1'b0, 4'hF);

    cur_mask = 4'hF;
    for (int b = 0; b < 20; b++) begin
      nxt_mask = 4'($urandom_range(15, 1));
      for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(65535)) - 32768;
      pc = $countones(cur_mask);
      dup = (pc >= 2 && $urandom_range(3) == 0) ? int'($urandom_range(1000)) : NO_DUP;
      dr  = ($urandom_range(4) == 0) ? int'($urandom_range(3)) : -1;
      run_batch(cur_mask, v, dup, 1, dr, 1'b0, nxt_mask);
      cur_mask = nxt_mask;
    end

    lane_mask = 4'b0000;
    rst = 1'b0;
    step();
    rst = 1'b1;
    pc = ls_count;
    for (int i = 0; i < 4; i++) pulse(i, 11 * (i + 1));
    repeat (5) step();
    check_val("mask0_valid", int'(out_valid), 0);
    check_val("mask0_busy", int'(busy), 0);
    check_val("mask0_ls", ls_count - pc, 0);
    check_val("mask0_overrun", int'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
